// File: rtl/nanb_judge_if.sv
// Guess/result bus of the nAnB judge.
// master = game front-end, slave = judge.
interface nanb_judge_if;
  logic        iStart;
  logic        iSecret_load;
  logic [15:0] iSecret;
  logic [15:0] iGuess;
  logic        iGuess_valid;
  logic        oReady;
  logic        oResult_valid;
  logic [2:0]  oA;
  logic [2:0]  oB;
  logic        oErr;
  logic [7:0]  oTries;
  logic        oWin;
  logic        oLose;
  logic [15:0] oSecret;

  modport master (
    output iStart, iSecret_load, iSecret,
    output iGuess, iGuess_valid,
    input  oReady, oResult_valid, oA, oB, oErr,
    input  oTries, oWin, oLose, oSecret
  );

  modport slave (
    input  iStart, iSecret_load, iSecret,
    input  iGuess, iGuess_valid,
    output oReady, oResult_valid, oA, oB, oErr,
    output oTries, oWin, oLose, oSecret
  );
endinterface

// File: rtl/nanb_judge.sv
// nAnB (Bulls and Cows) code-maker and referee.
// Draws/loads a secret and scores guesses serially.
module nanb_judge #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 10
) (
  input logic         iClk,
  input logic         iRst_n,
  nanb_judge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GEN, WAIT, CHECK, SCORE, RESULT, WON, LOST
  } state_t;

  localparam logic [7:0] MAXT = 8'(MAX_TRIES);

  state_t      state;
  state_t      nxt;
  logic [15:0] lfsr;
  logic [15:0] secret;
  logic [15:0] guess;
  logic [15:0] used;
  logic [1:0]  dcnt;
  logic [1:0]  pi;
  logic [1:0]  pj;
  logic [2:0]  acc_a;
  logic [2:0]  acc_b;
  logic [2:0]  a_q;
  logic [2:0]  b_q;
  logic [2:0]  a_nxt;
  logic [2:0]  b_nxt;
  logic        err_q;
  logic        win_q;
  logic        lose_q;
  logic [7:0]  tries;
  logic [3:0]  cand;
  logic [3:0]  sd;
  logic [3:0]  gd;
  logic [3:0]  g0, g1, g2, g3;
  logic        cand_ok;
  logic        bad;
  logic        hit;
  logic        last;
  logic        ready;
  logic        rvalid;

  function automatic logic [3:0] dig(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    logic [3:0] d;
    case (k)
      2'd0:    d = v[15:12];
      2'd1:    d = v[11:8];
      2'd2:    d = v[7:4];
      default: d = v[3:0];
    endcase
    return d;
  endfunction

  assign cand    = lfsr[3:0];
  assign cand_ok = (cand < 4'd10) && !used[cand];

  assign g0 = guess[15:12];
  assign g1 = guess[11:8];
  assign g2 = guess[7:4];
  assign g3 = guess[3:0];

  assign bad = (g0 > 4'd9) || (g1 > 4'd9)
            || (g2 > 4'd9) || (g3 > 4'd9)
            || (g0 == g1) || (g0 == g2)
            || (g0 == g3) || (g1 == g2)
            || (g1 == g3) || (g2 == g3);

  assign sd    = dig(secret, pi);
  assign gd    = dig(guess, pj);
  assign hit   = (sd == gd);
  assign a_nxt = acc_a + {2'b0, hit && (pi == pj)};
  assign b_nxt = acc_b + {2'b0, hit && (pi != pj)};
  assign last  = (pi == 2'd3) && (pj == 2'd3);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (bus.iSecret_load) begin
      nxt = WAIT;
    end else if (bus.iStart) begin
      nxt = GEN;
    end else begin
      unique case (state)
        IDLE:   nxt = IDLE;
        GEN:    if (cand_ok && dcnt == 2'd3) nxt = WAIT;
        WAIT:   if (bus.iGuess_valid) nxt = CHECK;
        CHECK:  nxt = bad ? RESULT : SCORE;
        SCORE:  if (last) nxt = RESULT;
        RESULT: begin
          unique case (1'b1)
            err_q:           nxt = WAIT;
            (a_q == 3'd4):   nxt = WON;
            (tries == MAXT): nxt = LOST;
            default:         nxt = WAIT;
          endcase
        end
        WON:    nxt = WON;
        LOST:   nxt = LOST;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready  = (state == WAIT);
    rvalid = (state == RESULT);
  end

  // LFSR free-runs in every state; start/load never reseed it
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      lfsr   <= LFSR_SEED;
      secret <= '0;
      guess  <= '0;
      used   <= '0;
      dcnt   <= '0;
      pi     <= '0;
      pj     <= '0;
      acc_a  <= '0;
      acc_b  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      err_q  <= 1'b0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
      tries  <= '0;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (bus.iSecret_load || bus.iStart) begin
        tries  <= '0;
        win_q  <= 1'b0;
        lose_q <= 1'b0;
        err_q  <= 1'b0;
        a_q    <= '0;
        b_q    <= '0;
        if (bus.iSecret_load) begin
          secret <= bus.iSecret;
        end else begin
          secret <= '0;
          used   <= '0;
          dcnt   <= '0;
        end
      end else begin
        unique case (state)
          GEN: begin
            if (cand_ok) begin
              case (dcnt)
                2'd0:    secret[15:12] <= cand;
                2'd1:    secret[11:8]  <= cand;
                2'd2:    secret[7:4]   <= cand;
                default: secret[3:0]   <= cand;
              endcase
              used[cand] <= 1'b1;
              dcnt       <= dcnt + 2'd1;
            end
          end
          WAIT: begin
            if (bus.iGuess_valid) guess <= bus.iGuess;
          end
          CHECK: begin
            if (bad) begin
              err_q <= 1'b1;
              a_q   <= '0;
              b_q   <= '0;
            end else begin
              acc_a <= '0;
              acc_b <= '0;
              pi    <= '0;
              pj    <= '0;
            end
          end
          SCORE: begin
            acc_a <= a_nxt;
            acc_b <= b_nxt;
            pj    <= pj + 2'd1;
            if (pj == 2'd3) pi <= pi + 2'd1;
            // results and tries become visible in RESULT
            if (last) begin
              a_q   <= a_nxt;
              b_q   <= b_nxt;
              err_q <= 1'b0;
              tries <= tries + 8'd1;
            end
          end
          RESULT: begin
            if (!err_q) begin
              if (a_q == 3'd4)       win_q  <= 1'b1;
              else if (tries == MAXT) lose_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.oReady        = ready;
  assign bus.oResult_valid = rvalid;
  assign bus.oA            = a_q;
  assign bus.oB            = b_q;
  assign bus.oErr          = err_q;
  assign bus.oTries        = tries;
  assign bus.oWin          = win_q;
  assign bus.oLose         = lose_q;
  assign bus.oSecret       = secret;

endmodule

// File: tb/tb_nanb_judge.sv
// Bench for nanb_judge: directed games with a
// scoreboard of expected results and latencies.
module tb_nanb_judge;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  nanb_judge_if bus ();

  nanb_judge #(
    .LFSR_SEED(16'hACE1),
    .MAX_TRIES(3)
  ) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       err;
    logic [7:0] tries;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  int          acc_q[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] sec_m;
  logic [7:0]  tries_m;
  exp_t        m_e;
  int          m_t0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [15:0] s,
    input logic [15:0] g,
    input logic [7:0]  t
  );
    exp_t       e;
    logic [3:0] gs[4];
    logic [3:0] ss[4];
    e.a = 0; e.b = 0; e.err = 0;
    for (int k = 0; k < 4; k++) begin
      gs[k] = g[15-4*k -: 4];
      ss[k] = s[15-4*k -: 4];
    end
    for (int k = 0; k < 4; k++) begin
      if (gs[k] > 4'd9) e.err = 1;
      for (int m = k + 1; m < 4; m++)
        if (gs[k] == gs[m]) e.err = 1;
    end
    if (!e.err) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (ss[i] == gs[j]) begin
            if (i == j) e.a++;
            else        e.b++;
          end
      e.tries = t + 8'd1;
      e.lat   = 18;
    end else begin
      e.tries = t;
      e.lat   = 2;
    end
    return e;
  endfunction

  function automatic logic sec_ok(input logic [15:0] s);
    logic ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (s[15-4*k -: 4] > 4'd9) ok = 1'b0;
      for (int m = k + 1; m < 4; m++)
        if (s[15-4*k -: 4] == s[15-4*m -: 4]) ok = 1'b0;
    end
    return ok;
  endfunction

  // accept edge bookkeeping: cycle index of the handshake
  always @(posedge clk) begin
    if (bus.iGuess_valid && bus.oReady)
      acc_q.push_back(cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (bus.oResult_valid) begin
      if (sb.size() == 0 || acc_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexp_result: got result_valid=1 expected 0");
      end else begin
        m_e  = sb.pop_front();
        m_t0 = acc_q.pop_front();
        check("res_a", 32'(bus.oA), 32'(m_e.a));
        check("res_b", 32'(bus.oB), 32'(m_e.b));
        check("res_err", 32'(bus.oErr), 32'(m_e.err));
        check("res_tries", 32'(bus.oTries), 32'(m_e.tries));
        check("res_latency", 32'(cyc - m_t0), 32'(m_e.lat));
      end
    end
  end

  task automatic load(input logic [15:0] s);
    @(negedge clk);
    bus.iSecret      = s;
    bus.iSecret_load = 1'b1;
    @(negedge clk);
    bus.iSecret_load = 1'b0;
    sec_m   = s;
    tries_m = 0;
    sb.delete();
    acc_q.delete();
  endtask

  task automatic drive_guess(input logic [15:0] g, input bit expect_res);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!bus.oReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("guess_ready", 32'(bus.oReady), 32'd1);
    bus.iGuess       = g;
    bus.iGuess_valid = 1'b1;
    if (expect_res) begin
      e       = model(sec_m, g, tries_m);
      tries_m = e.tries;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.iGuess_valid = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("result_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic start_game();
    int n = 0;
    @(negedge clk);
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    tries_m = 0;
    while (!bus.oReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("gen_ready", 32'(bus.oReady), 32'd1);
    check("gen_secret_ok", 32'(sec_ok(bus.oSecret)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iStart       = 1'b0;
    bus.iSecret_load = 1'b0;
    bus.iSecret      = '0;
    bus.iGuess       = '0;
    bus.iGuess_valid = 1'b0;
    sec_m   = '0;
    tries_m = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.oReady), 32'd0);
    check("rst_rvalid", 32'(bus.oResult_valid), 32'd0);
    check("rst_secret", 32'(bus.oSecret), 32'd0);
    check("rst_tries", 32'(bus.oTries), 32'd0);
    check("rst_flags",
          32'({bus.oA, bus.oB, bus.oErr, bus.oWin, bus.oLose}),
          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(bus.oReady), 32'd0);

    // win on first try
    load(16'h1234);
    check("load_ready", 32'(bus.oReady), 32'd1);
    check("load_secret", 32'(bus.oSecret), 32'h1234);
    drive_guess(16'h1234, 1'b1);
    wait_results();
    @(negedge clk);
    check("win_flag", 32'(bus.oWin), 32'd1);
    check("win_ready", 32'(bus.oReady), 32'd0);
    bus.iGuess       = 16'h5678;
    bus.iGuess_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.iGuess_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("win_tries_hold", 32'(bus.oTries), 32'd1);

    // partial scores
    load(16'h1234);
    check("reload_win_clr", 32'(bus.oWin), 32'd0);
    drive_guess(16'h4321, 1'b1);
    wait_results();
    @(negedge clk);
    check("back_to_wait", 32'(bus.oReady), 32'd1);
    drive_guess(16'h1562, 1'b1);
    wait_results();

    // rejected guesses
    load(16'h1234);
    drive_guess(16'h1123, 1'b1);
    wait_results();
    drive_guess(16'h12A4, 1'b1);
    wait_results();
    check("err_tries", 32'(bus.oTries), 32'd0);

    // lose after MAX_TRIES
    load(16'h0987);
    repeat (3) begin
      drive_guess(16'h1234, 1'b1);
      wait_results();
    end
    @(negedge clk);
    check("lose_flag", 32'(bus.oLose), 32'd1);
    check("lose_win", 32'(bus.oWin), 32'd0);
    check("lose_ready", 32'(bus.oReady), 32'd0);
    bus.iGuess       = 16'h0987;
    bus.iGuess_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.iGuess_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("lose_tries_hold", 32'(bus.oTries), 32'd3);

    // random secrets
    start_game();
    check("start_lose_clr", 32'(bus.oLose), 32'd0);
    check("start_tries", 32'(bus.oTries), 32'd0);
    for (int r = 0; r < 999; r++) start_game();

    // load aborts a guess mid-SCORE
    load(16'h1234);
    drive_guess(16'h1243, 1'b1);
    wait_results();
    drive_guess(16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    bus.iSecret      = 16'h9876;
    bus.iSecret_load = 1'b1;
    @(negedge clk);
    bus.iSecret_load = 1'b0;
    sec_m = 16'h9876;
    tries_m = 0;
    acc_q.delete();
    check("abort_ready", 32'(bus.oReady), 32'd1);
    check("abort_tries", 32'(bus.oTries), 32'd0);
    check("abort_secret", 32'(bus.oSecret), 32'h9876);
    repeat (25) @(negedge clk);
    check("abort_still_wait", 32'(bus.oReady), 32'd1);

    // async reset mid-SCORE
    load(16'h1234);
    drive_guess(16'h1243, 1'b1);
    wait_results();
    drive_guess(16'h1234, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.oReady), 32'd0);
    check("arst_rvalid", 32'(bus.oResult_valid), 32'd0);
    check("arst_secret", 32'(bus.oSecret), 32'd0);
    check("arst_tries", 32'(bus.oTries), 32'd0);
    check("arst_flags",
          32'({bus.oA, bus.oB, bus.oErr, bus.oWin, bus.oLose}),
          32'd0);
    acc_q.delete();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("arst_idle", 32'(bus.oReady), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/nanb_judge.md
Name: nanb_judge

Overview:
Code-maker and referee side of the nAnB (Bulls and Cows) game. It holds a 4-digit secret with no repeated digits, taken either from an internal LFSR draw or from an external load. It accepts guesses over a valid/ready handshake and scores each one serially as xAyB. It returns the result with a one-cycle valid pulse, and tracks the attempt count plus the win and lose conditions for the display and LED logic.

Parameters:
LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.
MAX_TRIES, 10, number of scored valid guesses allowed before the game is lost (range 1..255).

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iStart  in  1  one-cycle pulse (debounced); begins a new game with a random secret
iSecret_load  in  1  one-cycle pulse; begins a new game with secret = iSecret
iSecret  in  16  4 BCD digits, [15:12] is the leftmost digit
iGuess  in  16  4 BCD digits, same ordering
iGuess_valid  in  1  guess offered
oReady  out  1  judge can accept a guess (state WAIT)
oResult_valid  out  1  one-cycle pulse; oA/oB/oErr are updated on this cycle
oA  out  3  digits matching in value and position (0..4)
oB  out  3  digits matching in value, wrong position (0..4)
oErr  out  1  last guess rejected (digit >9 or repeated digit)
oTries  out  8  count of scored valid guesses in the current game
oWin  out  1  level; game won
oLose  out  1  level; tries exhausted without a win
oSecret  out  16  current secret (debug/reveal)

Behaviour:
- Reset (async, iRst_n=0):
  - State IDLE; LFSR=LFSR_SEED.
  - All outputs 0, including oSecret=16'h0000 and oTries=0.
- LFSR steps every cycle in every state; it is never reset by start/load.
- States: IDLE, GEN, WAIT, CHECK, SCORE, RESULT, WON, LOST.
- Game start, from any state:
  - iSecret_load has priority over iStart when both are asserted.
  - iSecret_load: latch iSecret with no validity check; clear tries, win, lose, err, A, B; go to WAIT.
  - iStart: clear the same; clear the digit-used mask; go to GEN.
  - A start during CHECK/SCORE/RESULT aborts the guess; no oResult_valid is issued.
- GEN, one candidate per cycle from LFSR[3:0]:
  - Accept it if <10 and not already in the used mask.
  - Accepted digits fill the secret left to right, then the digit counter increments.
  - After the 4th accept, go to WAIT.
  - Digit 0 is legal in any position.
- WAIT: oReady=1. A guess is accepted on the edge where iGuess_valid & oReady; latch iGuess and go to CHECK. Accepts happen only in WAIT.
- CHECK, 1 cycle:
  - Invalid guess (any nibble >9, or any two nibbles equal) → RESULT with oErr=1, oA=oB=0; tries unchanged.
  - Otherwise → SCORE; clear the A/B accumulators; i=j=0.
- SCORE, 16 cycles:
  - Each cycle compare secret digit i with guess digit j (i = position in secret, j = position in guess, both 0..3 from the left). On equality: A++ if i==j, else B++.
  - j increments; on wrap, i increments. Leave after the (3,3) compare.
  - Accumulators are 3 bits wide and cannot overflow (max 4).
- RESULT, 1 cycle:
  - oResult_valid=1; oA/oB/oErr are registered this cycle and held until the next RESULT or game start.
  - Valid guess: oTries increments in this cycle.
  - Next state: A==4 → WON (oWin=1); else new tries==MAX_TRIES → LOST (oLose=1); else WAIT.
  - Win takes precedence over lose on the final try.
  - An erroring guess returns to WAIT.
- Latency: accept edge T → oResult_valid high in cycle T+18 for a valid guess, T+2 for an invalid one.
- WON/LOST: oReady=0; guesses are ignored; oWin/oLose hold until reset or game start.
- IDLE: oReady=0; only start/load act.

Test Plan:
- Reset, then iSecret_load with 16'h1234, then guess 16'h1234 → oResult_valid at T+18, oA=4, oB=0, oWin=1, oTries=1, oReady=0 afterwards.
- Secret 16'h1234, guess 16'h4321 → oA=0, oB=4, oTries=1, state returns to WAIT with oReady=1. Guess 16'h1562 → oA=1, oB=1, oTries=2.
- Secret 16'h1234; guesses 16'h1123 then 16'h12A4 → each gives oErr=1 at T+2, oA=oB=0, oTries stays 0.
- MAX_TRIES=3, secret 16'h0987, three guesses of 16'h1234 → third result oA=0, oB=0, oTries=3, oLose=1. A 4th iGuess_valid is ignored.
- iStart pulse from reset → within GEN, oSecret ends with 4 distinct digits all ≤9, then oReady=1. Repeat 1000 starts and check every secret has 4 distinct digits ≤9.
- iSecret_load pulse 5 cycles after a guess accept (mid-SCORE) → no oResult_valid, oTries=0, new secret loaded, oReady=1 on the next cycle. Async reset mid-SCORE → all outputs 0 immediately.
